// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, default tap masks and the feedback helper for lfsr_ranged.
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_e;
  localparam logic [7:0]  TAPS8  = 8'hE1;
  localparam logic [15:0] TAPS16 = 16'hD008;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  function automatic logic lfsr_fb(input logic [31:0] s, input logic [31:0] t);
    return ^(s & t);
  endfunction
endpackage

// File: rtl/lfsr_ranged_if.sv
// lfsr_ranged_if: seed, request and result handshake bundle for lfsr_ranged.
//   seed_valid_i/seed_i  : seed load
//   req_valid_i/req_ready_o/range_i : request, range sampled on accept
//   rand_valid_o/rand_ready_i/rand_o/rand_timeout_o : bounded result
//   lockup_o             : one-cycle pulse when a zero seed was replaced
// Signal suffixes are from the point of view of the random block (slave).
interface lfsr_ranged_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 5
);
  logic             seed_valid_i;
  logic [WIDTH-1:0] seed_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [OUT_W-1:0] range_i;
  logic             rand_valid_o;
  logic             rand_ready_i;
  logic [OUT_W-1:0] rand_o;
  logic             rand_timeout_o;
  logic             lockup_o;
  modport slave (
    input  seed_valid_i, seed_i, req_valid_i, range_i, rand_ready_i,
    output req_ready_o, rand_valid_o, rand_o, rand_timeout_o, lockup_o
  );
  modport master (
    output seed_valid_i, seed_i, req_valid_i, range_i, rand_ready_i,
    input  req_ready_o, rand_valid_o, rand_o, rand_timeout_o, lockup_o
  );
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR with step enable, seed load and zero-seed substitution.
//   clk_i, rst_ni  : clock, async active-low reset (state returns to SEED)
//   step_i         : advance one step this cycle
//   seed_valid_i   : load seed_i (wins over step_i); zero loads SEED instead
//   cand_o         : low OUT_W bits of the current registered state
//   lockup_o       : registered pulse, high the cycle after a zero seed load
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int             WIDTH = 16,
  parameter int             OUT_W = 5,
  parameter logic [WIDTH-1:0] TAPS = TAPS16,
  parameter logic [WIDTH-1:0] SEED = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [OUT_W-1:0] cand_o,
  output logic             lockup_o
);
  logic [WIDTH-1:0] state_q, state_d;
  logic             lockup_q, lockup_d;
  always_comb begin
    state_d  = seed_valid_i ? (seed_i == '0 ? SEED : seed_i)
             : step_i       ? {state_q[WIDTH-2:0], lfsr_fb(32'(state_q), 32'(TAPS))}
             :                state_q;
    lockup_d = seed_valid_i && seed_i == '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end
  assign cand_o   = state_q[OUT_W-1:0];
  assign lockup_o = lockup_q;
endmodule

// File: rtl/lfsr_ranged.sv
// lfsr_ranged: bounded random numbers in [0, range) by rejection sampling an LFSR.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : seed load, request (range_i), result (rand_o, rand_timeout_o), lockup_o
// Build option LFSR_RANGED_FREE_RUN_EN: the LFSR steps every cycle in every state;
// otherwise it only steps while drawing, so each request sees a deterministic sequence.
module lfsr_ranged
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               OUT_W     = 5,
  parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
  parameter logic [WIDTH-1:0] SEED      = 1,
  parameter int               MAX_TRIES = 16
) (
  input logic          clk_i,
  input logic          rst_ni,
  lfsr_ranged_if.slave bus
);
  localparam int CW = $clog2(MAX_TRIES + 1);
  state_e           state_q;
  logic [CW-1:0]    try_q;
  logic [OUT_W-1:0] range_q, rand_q, cand;
  logic             timeout_q, step, accept, last;
`ifdef LFSR_RANGED_FREE_RUN_EN
  assign step = 1'b1;
`else
  assign step = state_q == DRAW;
`endif
  lfsr_core #(.WIDTH(WIDTH), .OUT_W(OUT_W), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .step_i      (step),
    .seed_valid_i(bus.seed_valid_i),
    .seed_i      (bus.seed_i),
    .cand_o      (cand),
    .lockup_o    (bus.lockup_o)
  );
  // Range zero means the full 2^OUT_W span, so every candidate is accepted.
  assign accept = range_q == '0 || cand < range_q;
  assign last   = try_q == CW'(MAX_TRIES - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      try_q     <= '0;
      range_q   <= '0;
      rand_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          range_q <= bus.range_i;
          try_q   <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          try_q <= try_q + CW'(1);
          if (accept) begin
            rand_q    <= cand;
            timeout_q <= 1'b0;
            state_q   <= HOLD;
          end else if (last) begin
            // Zero is inside every range, so it is a safe fallback value.
            rand_q    <= '0;
            timeout_q <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: if (bus.rand_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready_o    = state_q == IDLE;
  assign bus.rand_valid_o   = state_q == HOLD;
  assign bus.rand_o         = rand_q;
  assign bus.rand_timeout_o = timeout_q;
endmodule

// File: doc/lfsr_ranged.md
Name: lfsr_ranged

Overview:
- Parametrised successor to the team's 8-bit LFSR.
- Provides a configurable-width Fibonacci LFSR with runtime seed loading and zero-seed lock-up protection.
- Adds a request/response handshake that returns a random value bounded to [0, range) by rejection sampling.
- Consumers are game and lab logic that need bounded random numbers, for example a random LED index or a random delay.

Parameters:
- WIDTH, 16: LFSR state width, legal range 4..32.
- OUT_W, 5: width of rand_o and range_i; must be <= WIDTH.
- TAPS, 16'hD008: feedback tap mask (bits 15,14,12,3 give x^16+x^15+x^13+x^4+1).
- SEED, 1: reset and fallback state; must be nonzero.
- MAX_TRIES, 16: maximum draws per request before the timeout fallback.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- seed_valid_i  input  1  load seed_i into the LFSR this cycle.
- seed_i  input  WIDTH  seed value.
- req_valid_i  input  1  request a bounded random value.
- req_ready_o  output  1  block can accept a request.
- range_i  input  OUT_W  exclusive upper bound; 0 means full 2^OUT_W range. Sampled on request accept.
- rand_valid_o  output  1  result available.
- rand_ready_i  input  1  consumer accepts the result.
- rand_o  output  OUT_W  bounded random result.
- rand_timeout_o  output  1  result was produced by the timeout fallback; valid with rand_valid_o.
- lockup_o  output  1  one-cycle pulse: a zero seed was replaced by SEED.

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - LFSR state = SEED, FSM = IDLE.
  - rand_o = 0, rand_valid_o = 0, rand_timeout_o = 0, lockup_o = 0.
  - try counter = 0, range_q = 0.
- LFSR step: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Candidate = state[OUT_W-1:0], the current registered state before the step.
- FSM states and transitions:
  - IDLE: req_ready_o=1. On req_valid_i, capture range_i into range_q, clear the try counter, go to DRAW. The LFSR holds.
  - DRAW: req_ready_o=0. Every cycle the LFSR steps and the try counter increments.
    - Accept if range_q==0 or candidate < range_q. On accept: rand_o <= candidate, rand_timeout_o <= 0, go to HOLD.
    - If the reject is the MAX_TRIES-th try: rand_o <= 0, rand_timeout_o <= 1, go to HOLD. Zero is always in range.
    - Otherwise stay in DRAW.
  - HOLD: rand_valid_o=1; rand_o and rand_timeout_o are stable. On rand_ready_i, go to IDLE. A new request is accepted no earlier than the cycle after the ack.
- Latency: request accepted in cycle 0; first candidate evaluated in cycle 1; earliest rand_valid_o in cycle 2.
- Seed load is accepted in any state and takes priority over a DRAW step in the same cycle. That DRAW cycle's candidate is still evaluated; the try count still increments.
- Zero-seed protection: seed_i==0 loads SEED instead and pulses lockup_o for one cycle. The all-zero state is otherwise unreachable.
- range_i changes after accept have no effect on the current request.
- rand_ready_i outside HOLD is ignored. req_valid_i outside IDLE is ignored (not queued).
- Reset mid-operation: an in-flight request is discarded; all registers return to reset values immediately.

Optional Feature:
- Macro LFSR_RANGED_FREE_RUN_EN.
- Defined: the LFSR steps every cycle in every state, so request timing adds entropy. Seed-load priority is unchanged.
- Undefined: the LFSR steps only in DRAW, giving a deterministic sequence per request, as specified above.

Decomposition:
- Package lfsr_pkg:
  - state enum (IDLE, DRAW, HOLD);
  - default tap constants for widths 8 (8'hE1), 16 (16'hD008), 32;
  - function for the feedback XOR.
- Sub-module lfsr_core: state register, step enable, seed load, zero-seed substitution, lockup pulse. Parametrised by WIDTH/TAPS/SEED.
- lfsr_ranged contains the FSM, try counter, range compare and output registers.

Test Plan:
- Full range: reset, range_i=0, one request -> rand_o=0x01 at cycle 2. Ack, second request -> rand_o=0x02.
- Rejection: seed_i=0x0004, then request with range_i=3 -> candidates 4, 8, 17 rejected. rand_o=2 after 4 DRAW cycles, rand_timeout_o=0.
- Timeout: from reset, range_i=1 -> 16 nonzero candidates (1,2,4,8,17,2,4,8,17,2,4,8,17,3,6,13). Then rand_valid_o=1, rand_o=0, rand_timeout_o=1.
- Zero seed: seed_valid_i with seed_i=0 -> lockup_o high for exactly 1 cycle; next request with range_i=0 returns 0x01.
- Backpressure: hold rand_ready_i=0 for 10 cycles in HOLD -> rand_o stable, req_ready_o=0, requests ignored; ack -> req_ready_o=1 next cycle.
- Async reset mid-DRAW: assert rst_ni low between clock edges -> rand_valid_o=0, req_ready_o=1 immediately; state returns to 0x0001.
